cpu_control_unit: RTL

//   Multi-cycle control FSM for the 16-bit CPU datapath (8 regs R0-R7, shared bus, ALU with A/G regs).

---
 rtl/cpu_ctrl_pkg.sv | 51 +++++
 rtl/onehot_dec3to8.sv | 15 +
 rtl/cpu_control_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit: opcodes, state encoding, ALU codes, IR fields.
// CTRL_LOGIC_OPS_EN adds the and/xor opcodes to the ALU instruction set.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StT1   = 2'd1,
        StT2   = 2'd2,
        StT3   = 2'd3
    } state_e;

    localparam logic [2:0] OpMv  = 3'b000;
    localparam logic [2:0] OpMvi = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpAnd = 3'b100;
    localparam logic [2:0] OpXor = 3'b101;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluXor = 2'b11;

    localparam int unsigned OpMsb = 8;
    localparam int unsigned OpLsb = 6;
    localparam int unsigned XMsb  = 5;
    localparam int unsigned XLsb  = 3;
    localparam int unsigned YMsb  = 2;
    localparam int unsigned YLsb  = 0;

    // True for opcodes that use the three-step A/G ALU sequence.
    function automatic logic is_alu_op(logic [2:0] op);
`ifdef CTRL_LOGIC_OPS_EN
        return (op == OpAdd) || (op == OpSub) || (op == OpAnd) || (op == OpXor);
`else
        return (op == OpAdd) || (op == OpSub);
`endif
    endfunction

    function automatic logic [1:0] alu_code(logic [2:0] op);
        case (op)
            OpSub:   return AluSub;
`ifdef CTRL_LOGIC_OPS_EN
            OpAnd:   return AluAnd;
            OpXor:   return AluXor;
`endif
            default: return AluAdd;
        endcase
    endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module onehot_dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM for the 16-bit CPU datapath (mv, mvi, add, sub; and/xor when
// CTRL_LOGIC_OPS_EN is defined). Controls are combinational from state and IR.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IR_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [7:0]        r_in,
    output logic [7:0]        r_out,
    output logic              din_out,
    output logic              a_in,
    output logic              g_in,
    output logic              g_out,
    output logic [1:0]        alu_op,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    state_e          state_q, state_d;
    logic [IR_W-1:0] ir_q;
    logic [2:0]      opcode, x_sel, y_sel;
    logic [2:0]      rin_sel, rout_sel;
    logic            rin_en, rout_en;

    // Upper din bits carry immediate data only; they never reach the control logic.
    logic unused_din;
    assign unused_din = ^din[DATA_W-1:IR_W];

    assign opcode = ir_q[OpMsb:OpLsb];
    assign x_sel  = ir_q[XMsb:XLsb];
    assign y_sel  = ir_q[YMsb:YLsb];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && run) begin
                ir_q <= din[IR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rin_en   = 1'b0;
        rin_sel  = x_sel;
        rout_en  = 1'b0;
        rout_sel = y_sel;
        din_out  = 1'b0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        g_out    = 1'b0;
        alu_op   = AluAdd;
        busy     = 1'b1;
        done     = 1'b0;
        illegal  = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (run) begin
                    state_d = StT1;
                end
            end
            StT1: begin
                if (opcode == OpMv) begin
                    rout_en = 1'b1;
                    rin_en  = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (opcode == OpMvi) begin
                    din_out = 1'b1;
                    rin_en  = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end else if (is_alu_op(opcode)) begin
                    rout_en  = 1'b1;
                    rout_sel = x_sel;
                    a_in     = 1'b1;
                    state_d  = StT2;
                end else begin
                    illegal = 1'b1;
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StT2: begin
                rout_en = 1'b1;
                g_in    = 1'b1;
                alu_op  = alu_code(opcode);
                state_d = StT3;
            end
            StT3: begin
                g_out   = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    onehot_dec3to8 u_rin_dec (
        .sel    (rin_sel),
        .en     (rin_en),
        .onehot (r_in)
    );

    onehot_dec3to8 u_rout_dec (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (r_out)
    );

endmodule
